// File: rtl/uart_pkg.sv
// Shared UART definitions: speed register width/reset value, frame shape and
// the transmitter state encoding (also used by uart_rx).
package uart_pkg;
  localparam int SPEED_W = 13;
  localparam logic [SPEED_W-1:0] DEFAULT_SPEED = 13'h1869;
  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS = FRAME_BITS - 2;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO for the transmitter. The head entry is visible
// combinationally so the FSM can pop and load it in the same cycle.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Storage has no reset; only the pointers and occupancy are cleared.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: buffered byte input, LSB-first serialisation at a
// programmable bit period of speed+1 clocks, registered line output.
module uart_tx
  import uart_pkg::*;
#(
  parameter int                 FIFO_DEPTH    = 4,
  parameter logic [SPEED_W-1:0] DEFAULT_SPEED = uart_pkg::DEFAULT_SPEED
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  input  logic [SPEED_W-1:0]          speed,
  input  logic                        set_speed,
  output logic                        tx,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  tx_state_t          state_q, state_d;
  logic [7:0]         shift_q, shift_d;
  logic [SPEED_W-1:0] speed_q;
  logic [SPEED_W-1:0] bit_len_q, bit_len_d;
  logic [SPEED_W-1:0] cnt_q, cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic               tx_q, tx_d;
  logic               load;
  logic               fifo_pop, fifo_full, fifo_empty;
  logic [7:0]         fifo_dout;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_valid),
    .pop   (fifo_pop),
    .din   (tx_data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign tx_ready = !fifo_full;
  assign tx_busy  = (state_q != IDLE) || !fifo_empty;
  assign tx       = tx_q;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_len_d = bit_len_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    tx_d      = 1'b1;
    load      = 1'b0;
    fifo_pop  = 1'b0;
    case (state_q)
      IDLE: load = !fifo_empty;
      START: begin
        tx_d = 1'b0;
        if (cnt_q == '0) begin
          cnt_d     = bit_len_q;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          cnt_d = cnt_q - SPEED_W'(1);
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (cnt_q == '0) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          cnt_d     = bit_len_q;
          if (bit_idx_q == 3'(DATA_BITS - 1)) state_d = STOP;
        end else begin
          cnt_d = cnt_q - SPEED_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          load    = !fifo_empty;
        end else begin
          cnt_d = cnt_q - SPEED_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Latching speed into bit_len here keeps a frame in flight at one rate.
    if (load) begin
      fifo_pop  = 1'b1;
      shift_d   = fifo_dout;
      bit_len_d = speed_q;
      cnt_d     = speed_q;
      state_d   = START;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      speed_q   <= DEFAULT_SPEED;
      bit_len_q <= DEFAULT_SPEED;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_len_q <= bit_len_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      if (set_speed) speed_q <= speed;
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table-driven single frames, hand-written
// corner sequences, and random bursts checked by a frame-level line monitor.
module tb_uart_tx;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [12:0] speed;
  logic        set_speed;
  logic        tx;
  logic        tx_busy;
  logic [2:0]  fifo_count;

  always #5 clk = ~clk;

  uart_tx #(.FIFO_DEPTH(4), .DEFAULT_SPEED(13'h1869)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .speed      (speed),
    .set_speed  (set_speed),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count)
  );

  typedef struct {
    logic [7:0] data;
    int         len;
  } frame_t;

  typedef struct {
    logic [12:0] spd;
    logic [7:0]  data;
    logic [9:0]  line;  // bit k = level of the k-th bit period on the wire
  } vec_t;

  frame_t exp_q[$];
  vec_t   vecs[5];

  int     checks = 0;
  int     errors = 0;
  bit     mon_en = 1'b0;
  bit     in_frame = 1'b0;
  bit     frame_bad;
  int     pos;
  frame_t cur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line monitor: each expected frame is start(0), 8 data bits LSB first,
  // stop(1), every level held exactly len clocks.
  always @(negedge clk) begin
    if (!mon_en || reset) begin
      in_frame = 1'b0;
    end else begin
      checks++;
      if (tx_ready !== (fifo_count != 3'd4) || fifo_count > 3'd4) begin
        errors++;
        $display("FAIL ready_rule: tx_ready=%b fifo_count=%0d", tx_ready, fifo_count);
      end
      if (!in_frame && tx === 1'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame: start bit seen with no byte pending, got tx=0 expected 1");
        end else begin
          cur       = exp_q.pop_front();
          in_frame  = 1'b1;
          pos       = 0;
          frame_bad = 1'b0;
        end
      end
      if (in_frame) begin
        int  b;
        logic e;
        b = pos / cur.len;
        e = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : cur.data[b-1];
        if (tx !== e) frame_bad = 1'b1;
        pos++;
        if (pos == 10 * cur.len) begin
          in_frame = 1'b0;
          checks++;
          if (frame_bad) begin
            errors++;
            $display("FAIL frame: data %02h bit_len %0d, got wrong level or duration, expected exact 8N1 waveform", cur.data, cur.len);
          end else begin
            $display("frame data=%02h bit_len=%0d ok", cur.data, cur.len);
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; tx_valid = 1'b0; set_speed = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_spd(input logic [12:0] s);
    speed = s; set_speed = 1'b1;
    @(negedge clk);
    set_speed = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    tx_valid = 1'b1; tx_data = d;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || in_frame) && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk("drain_in_time", i < budget, 1);
    tick();
    chk("drain_busy", tx_busy, 0);
    chk("drain_count", fifo_count, 0);
  endtask

  initial begin
    logic [19:0] cap;
    int          n;
    bit          bad;

    reset = 1'b1; tx_valid = 1'b0; tx_data = '0; speed = '0; set_speed = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("reset_tx", tx, 1);
    chk("reset_busy", tx_busy, 0);
    chk("reset_ready", tx_ready, 1);
    chk("reset_count", fifo_count, 0);

    vecs[0] = '{13'd3, 8'hA5, 10'h34A};
    vecs[1] = '{13'd0, 8'h00, 10'h200};
    vecs[2] = '{13'd0, 8'hFF, 10'h3FE};
    vecs[3] = '{13'd1, 8'h3C, 10'h278};
    vecs[4] = '{13'd2, 8'h81, 10'h302};

    for (int i = 0; i < 5; i++) begin
      do_reset();
      set_spd(vecs[i].spd);
      push(vecs[i].data);
      chk($sformatf("vec%0d_count", i), fifo_count, 1);
      chk($sformatf("vec%0d_tx_lat0", i), tx, 1);
      tick();
      chk($sformatf("vec%0d_tx_lat1", i), tx, 1);
      for (int b = 0; b < 10; b++) begin
        bad = 1'b0;
        for (int k = 0; k <= int'(vecs[i].spd); k++) begin
          tick();
          if (tx !== vecs[i].line[b]) bad = 1'b1;
        end
        chk($sformatf("vec%0d_bit%0d", i, b), bad, 0);
      end
      tick();
      chk($sformatf("vec%0d_busy_after", i), tx_busy, 0);
      $display("vector %0d speed=%0d data=%02h done", i, vecs[i].spd, vecs[i].data);
    end

    // Back-to-back frames at one clock per bit: no idle gap between them.
    do_reset();
    set_spd(13'd0);
    push(8'h00);
    push(8'hFF);
    for (int k = 0; k < 20; k++) begin
      tick();
      cap[k] = tx;
    end
    chk("b2b_waveform", cap, {10'h3FE, 10'h200});
    tick();
    chk("b2b_busy_after", tx_busy, 0);
    $display("back-to-back 00/FF done");

    mon_en = 1'b1;

    // Fill to full; the push made while full must be dropped.
    do_reset();
    set_spd(13'd1);
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back('{8'h10 + 8'(k), 2});
      push(8'h10 + 8'(k));
    end
    chk("full_count", fifo_count, 4);
    chk("full_ready", tx_ready, 0);
    push(8'hEE);
    chk("full_refused_count", fifo_count, 4);
    drain(1000);
    $display("fifo full / refused push done");

    // Push at count=DEPTH-1 on the same edge as the FSM pop.
    do_reset();
    set_spd(13'd1);
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back('{8'h60 + 8'(k), 2});
      push(8'h60 + 8'(k));
    end
    repeat (17) tick();
    chk("simul_count_before", fifo_count, 3);
    chk("simul_ready_before", tx_ready, 1);
    exp_q.push_back('{8'h6F, 2});
    push(8'h6F);
    chk("simul_count_after", fifo_count, 3);
    drain(1000);
    $display("simultaneous push/pop done");

    // Speed change mid-frame only affects the following frame.
    do_reset();
    set_spd(13'd3);
    exp_q.push_back('{8'hC6, 4});
    push(8'hC6);
    exp_q.push_back('{8'h39, 8});
    push(8'h39);
    repeat (10) tick();
    set_spd(13'd7);
    drain(1000);
    $display("speed change mid-frame done");

    // Random bursts with random valid gaps; refused pushes are not expected.
    for (int it = 0; it < 25; it++) begin
      int s, cnt_sent, nb;
      logic [7:0] d;
      s = $urandom_range(0, 3);
      set_spd(13'(s));
      nb = $urandom_range(1, 8);
      cnt_sent = 0;
      while (cnt_sent < nb) begin
        logic v;
        v = 1'($urandom_range(0, 1));
        d = 8'($urandom);
        tx_valid = v;
        tx_data = d;
        if (v && tx_ready) exp_q.push_back('{d, s + 1});
        tick();
        tx_valid = 1'b0;
        if (v) cnt_sent++;
      end
      drain(2000);
      $display("random burst %0d speed=%0d pushes=%0d done", it, s, nb);
    end

    // Reset during data bit 4 aborts the frame and clears the FIFO.
    do_reset();
    set_spd(13'd3);
    exp_q.push_back('{8'hC3, 4});
    push(8'hC3);
    exp_q.push_back('{8'h11, 4});
    push(8'h11);
    n = 0;
    while (!(in_frame && pos >= 21) && n < 300) begin
      tick();
      n++;
    end
    chk("abort_reached_bit4", n < 300, 1);
    mon_en = 1'b0;
    exp_q.delete();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_tx", tx, 1);
    chk("abort_count", fifo_count, 0);
    chk("abort_ready", tx_ready, 1);
    chk("abort_busy", tx_busy, 0);
    bad = 1'b0;
    repeat (60) begin
      tick();
      if (tx !== 1'b1) bad = 1'b1;
    end
    chk("abort_no_more_frames", bad, 0);

    // After reset the bit period returns to DEFAULT_SPEED+1 = 6250 clocks.
    push(8'h01);
    n = 0;
    while (tx !== 1'b0 && n < 10) begin
      tick();
      n++;
    end
    chk("default_start_seen", n < 10, 1);
    n = 0;
    while (tx === 1'b0 && n < 7000) begin
      n++;
      tick();
    end
    chk("default_speed_bit_len", n, 6250);
    do_reset();
    $display("reset abort / default speed done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
